// File: rtl/loteria_pkg.sv
// rtl/loteria_pkg.sv - shared state, tier and points definitions for loteria_multi
package loteria_pkg;

    typedef enum logic [1:0] {
        CARGA  = 2'd0,
        APOSTA = 2'd1,
        APURA  = 2'd2,
        RESULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TIER_NONE = 2'd0,
        TIER_LOW  = 2'd1,
        TIER_MID  = 2'd2,
        TIER_TOP  = 2'd3
    } tier_t;

    localparam logic [2:0] PTS_NONE = 3'd0;
    localparam logic [2:0] PTS_LOW  = 3'd1;
    localparam logic [2:0] PTS_MID  = 3'd2;
    localparam logic [2:0] PTS_TOP  = 3'd4;

    // Adds instead of subtracting so a short bet never wraps below zero
    function automatic tier_t tier_of(input logic [7:0] hits, input logic [7:0] bet_len);
        if (hits == bet_len)
            return TIER_TOP;
        else if (hits + 8'd1 == bet_len)
            return TIER_MID;
        else if (hits + 8'd2 == bet_len)
            return TIER_LOW;
        else
            return TIER_NONE;
    endfunction

    function automatic logic [2:0] points_of(input tier_t t);
        case (t)
            TIER_TOP: return PTS_TOP;
            TIER_MID: return PTS_MID;
            TIER_LOW: return PTS_LOW;
            default:  return PTS_NONE;
        endcase
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] inc,
                                            input logic [15:0] max);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, inc};
        return (s > {1'b0, max}) ? max : s[15:0];
    endfunction

endpackage

// File: rtl/loteria_match.sv
// rtl/loteria_match.sv - combinational lookup of a number among the valid slots
module loteria_match #(
    parameter int NUM_W   = 4,
    parameter int BET_LEN = 4
) (
    input  logic [NUM_W-1:0]         numero,
    input  logic [BET_LEN*NUM_W-1:0] slots,
    input  logic [BET_LEN-1:0]       valid,
    output logic                     hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < BET_LEN; i++) begin
            if (valid[i] && (slots[i*NUM_W +: NUM_W] == numero))
                hit = 1'b1;
        end
    end

endmodule

// File: rtl/loteria_multi.sv
// rtl/loteria_multi.sv - multi-player lottery: draw load, bets, serial scoring, result
module loteria_multi
    import loteria_pkg::*;
#(
    parameter int NUM_W     = 4,
    parameter int BET_LEN   = 4,
    parameter int N_PLAYERS = 2,
    parameter int SCORE_W   = 5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_W-1:0]               numero,
    input  logic                           insere,
    input  logic                           fim,
    input  logic                           fim_jogo,
    output logic [1:0]                     premio,
    output logic [$clog2(N_PLAYERS)-1:0]   vencedor,
    output logic                           empate,
    output logic [N_PLAYERS*SCORE_W-1:0]   pontos,
    output logic                           resultado_valido,
    output logic                           erro
);

    localparam int CNT_W  = $clog2(BET_LEN + 1);
    localparam int SLOT_W = $clog2(BET_LEN);
    localparam int PW     = $clog2(N_PLAYERS);
    localparam logic [15:0]      SCORE_MAX   = 16'((1 << SCORE_W) - 1);
    localparam logic [CNT_W-1:0] LAST_SLOT   = CNT_W'(BET_LEN - 1);
    localparam logic [CNT_W-1:0] FULL        = CNT_W'(BET_LEN);
    localparam logic [PW-1:0]    LAST_PLAYER = PW'(N_PLAYERS - 1);

    state_t state, state_nxt;
    logic [BET_LEN-1:0][NUM_W-1:0]   draw, bet;
    logic [CNT_W-1:0]                draw_cnt, bet_cnt;
    logic [BET_LEN-1:0]              draw_vld, bet_vld, aposta_vld;
    logic [N_PLAYERS-1:0][CNT_W-1:0] hits;
    logic [N_PLAYERS-1:0][SCORE_W-1:0] score;
    logic [PW-1:0]                   player, best_idx, best_idx_nxt;
    logic [CNT_W-1:0]                best_hits, best_nxt, cur_hits;
    logic                            tie, tie_nxt;
    logic                            dup_hit, draw_hit, rep_hit;
    logic                            take_draw, take_bet, next_player, err_nxt;
    tier_t                           cur_tier;

    always_comb begin
        draw_vld = '0;
        bet_vld  = '0;
        for (int i = 0; i < BET_LEN; i++) begin
            draw_vld[i] = CNT_W'(i) < draw_cnt;
            bet_vld[i]  = CNT_W'(i) < bet_cnt;
        end
        aposta_vld = draw_vld & {BET_LEN{state == APOSTA}};
    end

    loteria_match #(.NUM_W(NUM_W), .BET_LEN(BET_LEN)) u_dup (
        .numero(numero), .slots(draw), .valid(draw_vld), .hit(dup_hit)
    );
    loteria_match #(.NUM_W(NUM_W), .BET_LEN(BET_LEN)) u_hit (
        .numero(numero), .slots(draw), .valid(aposta_vld), .hit(draw_hit)
    );
    loteria_match #(.NUM_W(NUM_W), .BET_LEN(BET_LEN)) u_rep (
        .numero(numero), .slots(bet), .valid(bet_vld), .hit(rep_hit)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= CARGA;
        else
            state <= state_nxt;
    end

    // Strobe priority is fim_jogo > fim > insere; lower strobes are simply not decoded
    always_comb begin
        state_nxt   = state;
        take_draw   = 1'b0;
        take_bet    = 1'b0;
        next_player = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            CARGA: begin
                if (fim_jogo || fim) begin
                    err_nxt = 1'b1;
                end else if (insere) begin
                    if (dup_hit) begin
                        err_nxt = 1'b1;
                    end else begin
                        take_draw = 1'b1;
                        if (draw_cnt == LAST_SLOT)
                            state_nxt = APOSTA;
                    end
                end
            end
            APOSTA: begin
                if (fim_jogo) begin
                    state_nxt = APURA;
                end else if (fim) begin
                    if (player == LAST_PLAYER)
                        state_nxt = APURA;
                    else
                        next_player = 1'b1;
                end else if (insere) begin
                    if ((bet_cnt == FULL) || rep_hit)
                        err_nxt = 1'b1;
                    else
                        take_bet = 1'b1;
                end
            end
            APURA:   if (player == LAST_PLAYER) state_nxt = RESULT;
            RESULT:  state_nxt = CARGA;
            default: state_nxt = CARGA;
        endcase
    end

    always_comb begin
        cur_hits     = hits[player];
        cur_tier     = tier_of(8'(cur_hits), 8'(BET_LEN));
        best_nxt     = best_hits;
        best_idx_nxt = best_idx;
        tie_nxt      = tie;
        if (player == '0) begin
            best_nxt     = cur_hits;
            best_idx_nxt = '0;
            tie_nxt      = 1'b0;
        end else if (cur_hits > best_hits) begin
            best_nxt     = cur_hits;
            best_idx_nxt = player;
            tie_nxt      = 1'b0;
        end else if (cur_hits == best_hits) begin
            tie_nxt      = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            draw      <= '0;
            bet       <= '0;
            draw_cnt  <= '0;
            bet_cnt   <= '0;
            hits      <= '0;
            score     <= '0;
            player    <= '0;
            best_hits <= '0;
            best_idx  <= '0;
            tie       <= 1'b0;
            premio    <= '0;
            vencedor  <= '0;
            empate    <= 1'b0;
            erro      <= 1'b0;
        end else begin
            erro <= err_nxt;
            if (take_draw) begin
                draw[draw_cnt[SLOT_W-1:0]] <= numero;
                draw_cnt <= draw_cnt + 1'b1;
            end
            if (take_bet) begin
                bet[bet_cnt[SLOT_W-1:0]] <= numero;
                bet_cnt <= bet_cnt + 1'b1;
                if (draw_hit)
                    hits[player] <= hits[player] + 1'b1;
            end
            if (next_player) begin
                player  <= player + 1'b1;
                bet_cnt <= '0;
            end
            if (state == APOSTA && state_nxt == APURA) begin
                player  <= '0;
                bet_cnt <= '0;
            end
            if (state == APURA) begin
                score[player] <= SCORE_W'(sat_add(16'(score[player]), 16'(points_of(cur_tier)), SCORE_MAX));
                best_hits <= best_nxt;
                best_idx  <= best_idx_nxt;
                tie       <= tie_nxt;
                if (player == LAST_PLAYER) begin
                    premio   <= tier_of(8'(best_nxt), 8'(BET_LEN));
                    vencedor <= best_idx_nxt;
                    empate   <= tie_nxt;
                end else begin
                    player <= player + 1'b1;
                end
            end
            if (state == RESULT) begin
                draw     <= '0;
                draw_cnt <= '0;
                bet_cnt  <= '0;
                hits     <= '0;
                player   <= '0;
            end
        end
    end

    assign pontos           = score;
    assign resultado_valido = (state == RESULT);

endmodule

// File: tb/tb_loteria_multi.sv
// tb/tb_loteria_multi.sv - self-checking bench for loteria_multi
module tb_loteria_multi;

    localparam int NUM_W     = 4;
    localparam int BET_LEN   = 4;
    localparam int N_PLAYERS = 2;
    localparam int SCORE_W   = 5;
    localparam int SMAX      = 31;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [NUM_W-1:0] numero = '0;
    logic             insere = 1'b0, fim = 1'b0, fim_jogo = 1'b0;
    logic [1:0]       premio;
    logic [0:0]       vencedor;
    logic             empate;
    logic [N_PLAYERS*SCORE_W-1:0] pontos;
    logic             resultado_valido, erro;

    always #5 clock = ~clock;

    loteria_multi #(.NUM_W(NUM_W), .BET_LEN(BET_LEN), .N_PLAYERS(N_PLAYERS), .SCORE_W(SCORE_W)) dut (
        .clock(clock), .reset(reset), .numero(numero), .insere(insere), .fim(fim),
        .fim_jogo(fim_jogo), .premio(premio), .vencedor(vencedor), .empate(empate),
        .pontos(pontos), .resultado_valido(resultado_valido), .erro(erro)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference model: lists of numbers and a phase, rules applied directly
    int m_st;
    int m_draw [BET_LEN];
    int m_nd;
    int m_bet [N_PLAYERS][BET_LEN];
    int m_nb [N_PLAYERS];
    int m_pl;
    int m_score [N_PLAYERS];

    task automatic model_round_clear();
        m_st = 0; m_nd = 0; m_pl = 0;
        for (int p = 0; p < N_PLAYERS; p++) m_nb[p] = 0;
    endtask

    function automatic int tier_f(input int h);
        if (h == BET_LEN) return 3;
        if (h == BET_LEN - 1) return 2;
        if (h == BET_LEN - 2) return 1;
        return 0;
    endfunction

    function automatic int pts_f(input int t);
        case (t)
            3: return 4;
            2: return 2;
            1: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_result(output int e_pr, output int e_v, output int e_emp);
        int h [N_PLAYERS];
        int best, cnt;
        best = -1; e_v = 0; cnt = 0;
        for (int p = 0; p < N_PLAYERS; p++) begin
            h[p] = 0;
            for (int k = 0; k < m_nb[p]; k++)
                for (int d = 0; d < BET_LEN; d++)
                    if (m_bet[p][k] == m_draw[d]) h[p]++;
            if (h[p] > best) begin best = h[p]; e_v = p; end
        end
        for (int p = 0; p < N_PLAYERS; p++) if (h[p] == best) cnt++;
        e_emp = (cnt > 1) ? 1 : 0;
        e_pr  = tier_f(best);
        for (int p = 0; p < N_PLAYERS; p++) begin
            m_score[p] = m_score[p] + pts_f(tier_f(h[p]));
            if (m_score[p] > SMAX) m_score[p] = SMAX;
        end
        model_round_clear();
    endtask

    task automatic act(input bit i, input bit f, input bit j, input int n, input string tag);
        int e, found;
        e = 0; found = 0;
        if (m_st == 0) begin
            if (j || f) e = 1;
            else if (i) begin
                for (int k = 0; k < m_nd; k++) if (m_draw[k] == n) found = 1;
                if (found != 0) e = 1;
                else begin
                    m_draw[m_nd] = n; m_nd++;
                    if (m_nd == BET_LEN) m_st = 1;
                end
            end
        end else if (m_st == 1) begin
            if (j) m_st = 2;
            else if (f) begin
                if (m_pl == N_PLAYERS - 1) m_st = 2; else m_pl++;
            end else if (i) begin
                for (int k = 0; k < m_nb[m_pl]; k++) if (m_bet[m_pl][k] == n) found = 1;
                if (m_nb[m_pl] == BET_LEN || found != 0) e = 1;
                else begin m_bet[m_pl][m_nb[m_pl]] = n; m_nb[m_pl]++; end
            end
        end
        @(negedge clock);
        insere = i; fim = f; fim_jogo = j; numero = NUM_W'(n);
        @(posedge clock); #1;
        insere = 1'b0; fim = 1'b0; fim_jogo = 1'b0;
        chk({tag, "_erro"}, int'(erro), e);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; insere = 1'b0; fim = 1'b0; fim_jogo = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        model_round_clear();
        for (int p = 0; p < N_PLAYERS; p++) m_score[p] = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_premio"}, int'(premio), 0);
        chk({tag, "_vencedor"}, int'(vencedor), 0);
        chk({tag, "_empate"}, int'(empate), 0);
        chk({tag, "_pontos"}, int'(pontos), 0);
        chk({tag, "_valid"}, int'(resultado_valido), 0);
        chk({tag, "_erro"}, int'(erro), 0);
    endtask

    // Called right after the closing strobe's edge; junk strobes during scoring must be ignored
    task automatic wait_result(input string tag);
        int cyc;
        chk({tag, "_valid_apura1"}, int'(resultado_valido), 0);
        @(negedge clock);
        insere = 1'b1; fim = 1'b1; fim_jogo = 1'b1; numero = NUM_W'($urandom_range(15));
        @(posedge clock); #1;
        chk({tag, "_ign_erro1"}, int'(erro), 0);
        chk({tag, "_valid_apura2"}, int'(resultado_valido), 0);
        @(posedge clock); #1;
        chk({tag, "_ign_erro2"}, int'(erro), 0);
        insere = 1'b0; fim = 1'b0; fim_jogo = 1'b0;
        cyc = 0;
        while (!resultado_valido && cyc < 10) begin
            @(posedge clock); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 0);
    endtask

    task automatic check_round(input string tag, input int e_pr, input int e_v, input int e_emp,
                               input int e_p0, input int e_p1);
        chk({tag, "_premio"}, int'(premio), e_pr);
        chk({tag, "_vencedor"}, int'(vencedor), e_v);
        chk({tag, "_empate"}, int'(empate), e_emp);
        chk({tag, "_pontos0"}, int'(pontos[SCORE_W-1:0]), e_p0);
        chk({tag, "_pontos1"}, int'(pontos[2*SCORE_W-1:SCORE_W]), e_p1);
        @(posedge clock); #1;
        chk({tag, "_valid_pulse"}, int'(resultado_valido), 0);
        chk({tag, "_premio_hold"}, int'(premio), e_pr);
    endtask

    typedef struct {
        logic [15:0] draw;
        int          nb0;
        logic [19:0] b0;
        int          nb1;
        logic [19:0] b1;
        bit          fj;
        int          premio;
        int          venc;
        int          emp;
        int          d0;
        int          d1;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        int pr, v, em, x, n;
        vecs[0] = '{16'h4321, 4, 20'h04321, 4, 20'h08765, 1'b0, 3, 0, 0, 4, 0};
        vecs[1] = '{16'h4321, 4, 20'h09321, 4, 20'h0A432, 1'b0, 2, 0, 1, 2, 2};
        vecs[2] = '{16'h8765, 4, 20'h03215, 4, 20'h00678, 1'b0, 2, 1, 0, 0, 2};
        vecs[3] = '{16'hCBA9, 4, 20'h021A9, 2, 20'h00039, 1'b0, 1, 0, 0, 1, 0};
        vecs[4] = '{16'h4321, 4, 20'h04321, 0, 20'h00000, 1'b1, 3, 0, 0, 4, 0};
        vecs[5] = '{16'h6543, 3, 20'h00433, 4, 20'h0CDEF, 1'b0, 1, 0, 0, 1, 0};
        vecs[6] = '{16'h4321, 4, 20'h04321, 4, 20'h01234, 1'b0, 3, 0, 1, 4, 4};
        vecs[7] = '{16'h8642, 0, 20'h00000, 4, 20'h02468, 1'b0, 3, 1, 0, 0, 4};

        // Reset state, then first insere lands in slot 0 (its repeat is a duplicate)
        do_reset();
        chk_zero("reset");
        act(1, 0, 0, 7, "first_ins");
        act(1, 0, 0, 7, "first_dup");

        // Duplicate draw number, strobes in CARGA, fifth bet entry
        do_reset();
        act(1, 0, 0, 1, "dup_a");
        act(1, 0, 0, 1, "dup_b");
        act(0, 1, 0, 0, "carga_fim");
        act(0, 0, 1, 0, "carga_fj");
        for (int k = 2; k <= 4; k++) act(1, 0, 0, k, "dup_draw");
        for (int k = 1; k <= 5; k++) act(1, 0, 0, k, "p0_bet");
        act(0, 1, 0, 0, "p0_fim");
        act(0, 1, 0, 0, "p1_fim");
        wait_result("dup");
        model_result(pr, v, em);
        check_round("dup", 3, 0, 0, 4, 0);

        for (int t = 0; t < 8; t++) begin
            do_reset();
            for (int k = 0; k < BET_LEN; k++) act(1, 0, 0, int'(vecs[t].draw[k*4 +: 4]), "tbl_draw");
            for (int k = 0; k < vecs[t].nb0; k++) act(1, 0, 0, int'(vecs[t].b0[k*4 +: 4]), "tbl_b0");
            if (vecs[t].fj) begin
                act(0, 0, 1, 0, "tbl_fj");
            end else begin
                act(0, 1, 0, 0, "tbl_fim0");
                for (int k = 0; k < vecs[t].nb1; k++) act(1, 0, 0, int'(vecs[t].b1[k*4 +: 4]), "tbl_b1");
                act(0, 1, 0, 0, "tbl_fim1");
            end
            wait_result("tbl");
            model_result(pr, v, em);
            check_round($sformatf("tbl%0d", t), vecs[t].premio, vecs[t].venc, vecs[t].emp,
                        vecs[t].d0, vecs[t].d1);
        end

        // Repeated top prizes for P0 until the score saturates
        do_reset();
        for (int r = 1; r <= 9; r++) begin
            for (int k = 1; k <= 4; k++) act(1, 0, 0, k, "sat_draw");
            for (int k = 1; k <= 4; k++) act(1, 0, 0, k, "sat_bet");
            act(0, 1, 0, 0, "sat_fim0");
            act(0, 1, 0, 0, "sat_fim1");
            wait_result("sat");
            model_result(pr, v, em);
            check_round($sformatf("sat%0d", r), 3, 0, 0, (4 * r > SMAX) ? SMAX : 4 * r, 0);
        end

        // fim_jogo with a coincident insere, then reset in the second scoring cycle
        do_reset();
        for (int k = 1; k <= 4; k++) act(1, 0, 0, k, "fj_draw");
        for (int k = 1; k <= 3; k++) act(1, 0, 0, k, "fj_bet");
        act(1, 0, 1, 4, "fj_ins");
        wait_result("fj");
        model_result(pr, v, em);
        check_round("fj", 2, 0, 0, 2, 0);
        for (int k = 1; k <= 4; k++) act(1, 0, 0, k, "rst_draw");
        for (int k = 1; k <= 3; k++) act(1, 0, 0, k, "rst_bet");
        act(0, 0, 1, 0, "rst_fj");
        @(posedge clock); #1;
        chk("rst_mid_pontos0", int'(pontos[SCORE_W-1:0]), 4);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_round_clear();
        for (int p = 0; p < N_PLAYERS; p++) m_score[p] = 0;
        chk_zero("rst_mid");
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            chk("rst_no_valid", int'(resultado_valido), 0);
        end

        // Randomized rounds against the model
        do_reset();
        for (int r = 0; r < 30; r++) begin
            while (m_st == 0) begin
                x = $urandom_range(99);
                if (x < 5)      act(0, 1, 0, 0, "rnd_carga_fim");
                else if (x < 8) act(0, 0, 1, 0, "rnd_carga_fj");
                else            act(1, 0, 0, int'($urandom_range(15)), "rnd_draw");
            end
            while (m_st == 1) begin
                x = $urandom_range(99);
                n = (x % 5 < 3) ? m_draw[$urandom_range(BET_LEN - 1)] : int'($urandom_range(15));
                if (x < 3)       act(1'($urandom_range(1)), 1'($urandom_range(1)), 1, n, "rnd_fj");
                else if (x < 22) act(1'($urandom_range(1)), 1, 0, n, "rnd_fim");
                else             act(1, 0, 0, n, "rnd_bet");
            end
            wait_result("rnd");
            model_result(pr, v, em);
            check_round($sformatf("rnd%0d", r), pr, v, em, m_score[0], m_score[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
